// File: rtl/regfile_param.sv
// Parametrised register file: two combinational read ports, one write port,
// optional hard-zero entry 0, clear sweep sequencer. Optional forwarding: REGFILE_BYPASS_EN.
module regfile_param #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 5,
  parameter int ZERO_REG0 = 1,
  parameter int DBG_IDX   = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr1,
  input  logic [ADDR_W-1:0] raddr2,
  output logic [DATA_W-1:0] rdata1,
  output logic [DATA_W-1:0] rdata2,
  input  logic              clr_req,
  output logic              busy,
  output logic              wr_drop,
  output logic [DATA_W-1:0] dbg_out
);

  localparam int NREG = 2 ** ADDR_W;
  localparam logic [ADDR_W:0] LAST_IDX = (ADDR_W + 1)'(NREG - 1);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  state_t            state_r;
  state_t            state_nxt_s;
  logic [ADDR_W:0]   idx_r;
  logic [DATA_W-1:0] mem_r [NREG];
  logic              wr_drop_r;
  logic              busy_s;
  logic              wr_en_s;
  logic              clr_en_s;
  logic              drop_s;
  logic              sweep_done_s;

  assign sweep_done_s = (idx_r == LAST_IDX);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (clr_req) state_nxt_s = CLEAR;
        else         state_nxt_s = IDLE;
      end
      CLEAR: begin
        if (sweep_done_s) state_nxt_s = IDLE;
        else              state_nxt_s = CLEAR;
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // Output decode: write accept, sweep clear strobe, dropped-write detect
  always_comb begin
    busy_s   = 1'b0;
    wr_en_s  = 1'b0;
    clr_en_s = 1'b0;
    drop_s   = 1'b0;
    case (state_r)
      IDLE: begin
        wr_en_s = we && !((ZERO_REG0 != 0) && (waddr == {ADDR_W{1'b0}}));
      end
      CLEAR: begin
        busy_s   = 1'b1;
        clr_en_s = 1'b1;
        drop_s   = we;
      end
      default: begin
        busy_s = 1'b0;
      end
    endcase
  end

  // Sweep index: parked at 0 while idle, one entry per cycle while clearing
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_r <= {(ADDR_W + 1){1'b0}};
    end else if (state_r == IDLE) begin
      idx_r <= {(ADDR_W + 1){1'b0}};
    end else begin
      idx_r <= idx_r + {{ADDR_W{1'b0}}, 1'b1};
    end
  end

  // Storage; a write accepted together with clr_req lands now and is swept later
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) mem_r[i] <= {DATA_W{1'b0}};
    end else begin
      if (wr_en_s)  mem_r[waddr] <= wdata;
      if (clr_en_s) mem_r[idx_r[ADDR_W-1:0]] <= {DATA_W{1'b0}};
    end
  end

  // Dropped-write pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_drop_r <= 1'b0;
    end else begin
      wr_drop_r <= drop_s;
    end
  end

  function automatic logic [DATA_W-1:0] rd_port(input logic [ADDR_W-1:0] ra);
    logic [DATA_W-1:0] v;
    if ((ZERO_REG0 != 0) && (ra == {ADDR_W{1'b0}})) begin
      v = {DATA_W{1'b0}};
`ifdef REGFILE_BYPASS_EN
    end else if (we && !busy_s && (ra == waddr)) begin
      v = wdata;
`endif
    end else begin
      v = mem_r[ra];
    end
    return v;
  endfunction

  // Read ports and debug tap
  always_comb begin
    rdata1  = rd_port(raddr1);
    rdata2  = rd_port(raddr2);
    dbg_out = mem_r[DBG_IDX];
  end

  assign busy    = busy_s;
  assign wr_drop = wr_drop_r;

endmodule

// File: tb/tb_regfile_param.sv
// Randomised self-checking bench for regfile_param against an array-based
// reference model of the register file and its clear sweep.
module tb_regfile_param;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  localparam int NREG = 32;
  localparam int DBG  = 12;

  logic        clk;
  logic        rst_n;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic [4:0]  raddr1;
  logic [4:0]  raddr2;
  logic [31:0] rdata1;
  logic [31:0] rdata2;
  logic        clr_req;
  logic        busy;
  logic        wr_drop;
  logic [31:0] dbg_out;

  regfile_param dut (
    .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata),
    .raddr1(raddr1), .raddr2(raddr2), .rdata1(rdata1), .rdata2(rdata2),
    .clr_req(clr_req), .busy(busy), .wr_drop(wr_drop), .dbg_out(dbg_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: contents, cycles of sweep remaining, pending drop pulse
  logic [31:0] m_mem [NREG];
  int          m_left;
  bit          m_drop;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
  endtask

  function automatic logic [31:0] exp_rd(input logic [4:0] a, input logic w,
                                         input logic [4:0] wa, input logic [31:0] wd);
    if (a == 5'd0) return 32'd0;
    if (BYP && w && (m_left == 0) && (a == wa)) return wd;
    return m_mem[a];
  endfunction

  function automatic void model_clear();
    for (int i = 0; i < NREG; i++) m_mem[i] = 32'd0;
    m_left = 0;
    m_drop = 1'b0;
  endfunction

  // One cycle: drive at negedge, check settled outputs, clock, update model
  task automatic step(input logic w, input logic [4:0] wa, input logic [31:0] wd,
                      input logic [4:0] a1, input logic [4:0] a2, input logic c);
    we = w; waddr = wa; wdata = wd; raddr1 = a1; raddr2 = a2; clr_req = c;
    #1;
    check("rdata1", rdata1, exp_rd(a1, w, wa, wd));
    check("rdata2", rdata2, exp_rd(a2, w, wa, wd));
    check("dbg_out", dbg_out, m_mem[DBG]);
    check("busy", {31'd0, busy}, (m_left > 0) ? 32'd1 : 32'd0);
    check("wr_drop", {31'd0, wr_drop}, {31'd0, m_drop});
    @(posedge clk);
    m_drop = w && (m_left > 0);
    if (m_left > 0) begin
      m_mem[NREG - m_left] = 32'd0;
      m_left--;
    end else begin
      if (w && (wa != 5'd0)) m_mem[wa] = wd;
      if (c) m_left = NREG;
    end
    @(negedge clk);
  endtask

  task automatic idle_step(input logic [4:0] a1, input logic [4:0] a2);
    step(1'b0, 5'd0, 32'd0, a1, a2, 1'b0);
  endtask

  // Async reset pulse applied mid-cycle; outputs must clear immediately
  task automatic pulse_reset(input logic [4:0] a1, input logic [4:0] a2);
    we = 1'b0; clr_req = 1'b0; raddr1 = a1; raddr2 = a2;
    #1;
    rst_n = 1'b0;
    #1;
    check("rst_rdata1", rdata1, 32'd0);
    check("rst_rdata2", rdata2, 32'd0);
    check("rst_dbg", dbg_out, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_wr_drop", {31'd0, wr_drop}, 32'd0);
    model_clear();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Run until busy falls, optional write to r4 at sweep cycle 3 and clr_req at cycle 10
  task automatic run_sweep(input bit wr4, input bit clr10, output int len);
    len = 0;
    for (int k = 0; k < 100; k++) begin
      if (!busy) break;
      len++;
      step((wr4 && k == 3) ? 1'b1 : 1'b0, 5'd4, 32'hCAFE_0004,
           DBG[4:0], 5'd4, (clr10 && k == 10) ? 1'b1 : 1'b0);
    end
  endtask

  int len;

  initial begin
    rst_n = 1'b0; we = 1'b0; waddr = 5'd0; wdata = 32'd0;
    raddr1 = 5'd0; raddr2 = 5'd0; clr_req = 1'b0;
    model_clear();
    #2;
    check("por_rdata1", rdata1, 32'd0);
    check("por_busy", {31'd0, busy}, 32'd0);
    check("por_wr_drop", {31'd0, wr_drop}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed write/read, hard-zero r0, same-cycle read of r3
    step(1'b1, 5'd7, 32'hDEAD_BEEF, 5'd7, 5'd7, 1'b0);
    idle_step(5'd7, 5'd0);
    check("r7_readback", rdata1, 32'hDEAD_BEEF);
    step(1'b1, 5'd0, 32'h0000_0005, 5'd0, 5'd0, 1'b0);
    idle_step(5'd0, 5'd7);
    check("r0_wr_drop", {31'd0, wr_drop}, 32'd0);
    step(1'b1, 5'd3, 32'h0000_1234, 5'd7, 5'd3, 1'b0);
    idle_step(5'd3, 5'd3);

    // Random traffic including occasional clears
    for (int i = 0; i < 300; i++) begin
      step(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom(),
           5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
           ($urandom_range(0, 39) == 0) ? 1'b1 : 1'b0);
    end
    while (busy) idle_step(5'd1, 5'd2);

    // Reset mid-run with populated entries
    for (int i = 0; i < NREG; i++) step(1'b1, 5'(i), $urandom() | 32'd1, 5'(i), 5'd7, 1'b0);
    pulse_reset(5'd12, 5'd7);
    for (int i = 0; i < NREG; i += 2) idle_step(5'(i), 5'(i + 1));

    // Fill, sweep with a dropped write to r4, then read everything back
    for (int i = 0; i < NREG; i++) step(1'b1, 5'(i), 32'hA5A5_A5A5, 5'(i), 5'd12, 1'b0);
    step(1'b0, 5'd0, 32'd0, 5'd4, 5'd12, 1'b1);
    run_sweep(1'b1, 1'b0, len);
    check("sweep_len", 32'(len), 32'd32);
    for (int i = 0; i < NREG; i += 2) idle_step(5'(i), 5'(i + 1));
    step(1'b1, 5'd9, 32'h0BAD_F00D, 5'd9, 5'd9, 1'b0);
    idle_step(5'd9, 5'd4);

    // Write to r12 on the clr_req edge, second clr_req mid-sweep ignored
    step(1'b1, 5'd12, 32'h0000_0077, 5'd12, 5'd12, 1'b1);
    run_sweep(1'b0, 1'b1, len);
    check("sweep_len_reclr", 32'(len), 32'd32);
    idle_step(5'd12, 5'd12);

    // Reset at sweep cycle 5, then a fresh full sweep
    for (int i = 1; i < NREG; i++) step(1'b1, 5'(i), 32'h1000_0000 + 32'(i), 5'(i), 5'd0, 1'b0);
    step(1'b0, 5'd0, 32'd0, 5'd12, 5'd20, 1'b1);
    for (int k = 0; k < 5; k++) idle_step(5'd12, 5'd20);
    pulse_reset(5'd20, 5'd31);
    idle_step(5'd12, 5'd31);
    step(1'b0, 5'd0, 32'd0, 5'd12, 5'd20, 1'b1);
    run_sweep(1'b0, 1'b0, len);
    check("sweep_len_after_rst", 32'(len), 32'd32);
    idle_step(5'd1, 5'd31);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/regfile_param.md
# regfile_param

Parametrised register file that succeeds the fixed 32×32 block in the processor datapath: configurable width and depth, two combinational read ports, one synchronous write port, an optional hard-zero register 0, and a per-entry clear sequencer. It sits between the decode stage, which supplies read addresses, and writeback, which supplies the write port. It also exports one debug register to the top-level watermark/observation logic.

## Interface
- DATA_W, 32, register width in bits
- ADDR_W, 5, address width; depth NREG = 2**ADDR_W
- ZERO_REG0, 1, 1 = entry 0 reads as 0 and ignores writes
- DBG_IDX, 12, entry index driven on dbg_out

- clk  in  1  clock; all state updates on posedge
- rst_n  in  1  asynchronous, active-low reset
- we  in  1  write enable (1 = write)
- waddr  in  ADDR_W  write address
- wdata  in  DATA_W  write data
- raddr1  in  ADDR_W  read port 1 address
- raddr2  in  ADDR_W  read port 2 address
- rdata1  out  DATA_W  read port 1 data, combinational
- rdata2  out  DATA_W  read port 2 data, combinational
- clr_req  in  1  request a full clear sweep
- busy  out  1  clear sweep in progress
- wr_drop  out  1  one-cycle pulse: a write was discarded because busy
- dbg_out  out  DATA_W  contents of entry DBG_IDX

## Operation
- Reset (rst_n = 0): all NREG entries go to 0 immediately. FSM goes to IDLE, sweep index goes to 0, busy = 0 and wr_drop = 0. Reset overrides everything, including a sweep in progress.
- FSM has two states:
  - IDLE: if clr_req = 1 at a posedge, go to CLEAR with index = 0.
  - CLEAR: each posedge writes 0 to entry[index] and increments index. After writing entry NREG-1, return to IDLE.
- Writes:
  - In IDLE, we = 1 at a posedge stores wdata into entry[waddr].
  - With ZERO_REG0 = 1 and waddr = 0, the write is silently ignored and wr_drop stays 0.
- Writes during CLEAR: we = 1 while busy = 1 is discarded, and wr_drop = 1 in the following cycle.
- Same edge in IDLE with we = 1 and clr_req = 1: the write is performed, then overwritten by the sweep. Final value is 0.
- clr_req while busy = 1 is ignored; it does not restart or extend the sweep.
- Reads: rdata1/rdata2 return entry[raddr]. With ZERO_REG0 = 1 and raddr = 0, the output is forced to 0 regardless of bypass.
- dbg_out = entry[DBG_IDX], not bypassed.
- Arithmetic: index is ADDR_W+1 bits so terminal detection does not wrap. No other arithmetic.

## Timing
- Write latency: data is visible on the read ports (without bypass) in the cycle after the write edge.
- Read latency: 0 cycles; purely combinational from raddr to rdata.
- busy rises the cycle after clr_req is sampled in IDLE and stays high for exactly NREG cycles.
- The first write accepted after the sweep is at the first edge where busy = 0.
- wr_drop is registered, high for one cycle per dropped write, and reset value 0.
- Reset values of all outputs: rdata1/rdata2 = 0 (entries are zero), busy = 0, wr_drop = 0, dbg_out = 0.

## Configuration
- REGFILE_BYPASS_EN defined:
  - While we = 1, busy = 0 and raddrN = waddr (and not the ZERO_REG0 zero case), rdataN = wdata in the same cycle. This is write-to-read forwarding for writeback → decode.
  - During CLEAR, bypass is disabled because the write is dropped.
- Not defined: no forwarding. rdataN reflects stored contents only, and a same-cycle read returns the old value.

## Test plan
- Reset then read: assert rst_n = 0 mid-run with entries nonzero → all rdata, dbg_out, busy and wr_drop read 0 immediately.
- Basic write/read: write 0xDEADBEEF to r7, read r7 next cycle → rdata1 = 0xDEADBEEF. Write 0x5 to r0 with ZERO_REG0 = 1 → r0 reads 0 and wr_drop = 0.
- Bypass: with REGFILE_BYPASS_EN, we = 1, waddr = raddr2 = 3, wdata = 0x1234 → rdata2 = 0x1234 in the same cycle. Without the macro, rdata2 holds the old value until the next cycle.
- Clear sweep: fill all entries with 0xA5A5A5A5, pulse clr_req → busy high for NREG (32) cycles, then all entries read 0. A write to r4 during busy → wr_drop pulses for 1 cycle and r4 stays 0.
- Simultaneous events: we = 1 (r12 ← 0x77) on the same edge as clr_req → dbg_out shows 0x77 for the sweep cycles before index 12, then 0 after. A second clr_req at sweep cycle 10 is ignored, so busy length is still 32.
- Reset mid-sweep: drop rst_n at sweep cycle 5 → busy = 0 immediately, all entries 0, and FSM is in IDLE (a new clr_req starts a full 32-cycle sweep).
